// File: rtl/mips_64_pkg.sv
// rtl/mips_64_pkg.sv - shared opcodes, field slices, instruction classes and pipeline register types
// Purpose: common definitions for the mips_64 core and its ALU.
// Ports: none (package).
package mips_64_pkg;

  // Width of every architectural datapath word; the pipeline structs below are sized from it.
  localparam int WORD_W = 64;

  // Instruction field slices within instr[31:0]
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Opcodes
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT,
    NOP
  } instr_type_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL
  } alu_op_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic [WORD_W-1:0] npc;
  } if_id_t;

  typedef struct packed {
    logic              valid;
    instr_type_t       itype;
    logic [5:0]        opcode;
    alu_op_t           alu_op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] imm;
    logic [WORD_W-1:0] npc;
    logic [4:0]        dest;
  } id_ex_t;

  typedef struct packed {
    logic              valid;
    instr_type_t       itype;
    logic [WORD_W-1:0] alu_out;
    logic [WORD_W-1:0] b;
    logic [4:0]        dest;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    instr_type_t       itype;
    logic [WORD_W-1:0] result;
    logic [4:0]        dest;
  } mem_wb_t;

  function automatic instr_type_t decode_type(input logic [5:0] op);
    instr_type_t t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                    t = RM_ALU;
      OP_LW:                                        t = LOAD;
      OP_SW:                                        t = STORE;
      OP_BNEQZ, OP_BEQZ:                            t = BRANCH;
      OP_HLT:                                       t = HALT;
      default:                                      t = NOP;
    endcase
    return t;
  endfunction

  // Loads/stores use ADD for address generation, hence ADD as the default.
  function automatic alu_op_t decode_alu(input logic [5:0] op);
    alu_op_t o;
    case (op)
      OP_SUB, OP_SUBI: o = ALU_SUB;
      OP_AND:          o = ALU_AND;
      OP_OR:           o = ALU_OR;
      OP_SLT, OP_SLTI: o = ALU_SLT;
      OP_MUL:          o = ALU_MUL;
      default:         o = ALU_ADD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mips_64_alu.sv
// rtl/mips_64_alu.sv - combinational integer ALU for the mips_64 core
// Purpose: ADD/SUB/AND/OR/SLT(signed)/MUL(low half), all wrapping modulo 2^XLEN.
// Ports: op (alu_op_t), a, b (XLEN operands), result (XLEN).
module mips_64_alu
  import mips_64_pkg::*;
#(
  parameter int XLEN = WORD_W
) (
  input  alu_op_t          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_MUL: result = a * b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mips_64_core.sv
// rtl/mips_64_core.sv - 5-stage in-order 64-bit MIPS-style core with split I/D memories
// Purpose: IF/ID/EX/MEM/WB pipeline, no forwarding except the WB->ID register bypass,
//          branches resolved in EX with a two-slot flush, HLT freezes fetch and sets HALTED.
// Ports: clk (rising-edge clock), rst_n (async active-low reset), halted (mirrors HALTED).
// REG_BANK, INSTRUCTION_MEMORY, DATA_MEMORY, PC, HALTED, TAKEN_BRANCH are loaded/inspected hierarchically.
module mips_64_core
  import mips_64_pkg::*;
#(
  parameter int XLEN       = WORD_W,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  // Architectural storage; deliberately not reset so software preloads survive reset.
  logic [XLEN-1:0] REG_BANK           [0:31];
  logic [63:0]     INSTRUCTION_MEMORY [0:IMEM_DEPTH-1];
  logic [XLEN-1:0] DATA_MEMORY        [0:DMEM_DEPTH-1];

  logic [XLEN-1:0] PC;
  logic            HALTED;
  logic            TAKEN_BRANCH;
  // Sticky once an HLT leaves ID: keeps fetch frozen while the HLT drains to WB.
  logic            halt_pend;

  if_id_t  if_id,  if_id_d;
  id_ex_t  id_ex,  id_ex_d;
  ex_mem_t ex_mem, ex_mem_d;
  mem_wb_t mem_wb, mem_wb_d;
  logic [XLEN-1:0] pc_d;

  // ---------------- WB ----------------
  logic wb_we;
  assign wb_we = mem_wb.valid && !HALTED && (mem_wb.dest != 5'd0) &&
                 (mem_wb.itype == RR_ALU || mem_wb.itype == RM_ALU || mem_wb.itype == LOAD);

  // ---------------- ID ----------------
  logic [5:0]      id_op;
  logic [4:0]      id_rs, id_rt, id_rd;
  logic [15:0]     id_imm16;
  instr_type_t     id_itype;
  logic            id_is_hlt;
  logic [XLEN-1:0] id_a, id_b;

  assign id_op     = if_id.instr[OP_HI:OP_LO];
  assign id_rs     = if_id.instr[RS_HI:RS_LO];
  assign id_rt     = if_id.instr[RT_HI:RT_LO];
  assign id_rd     = if_id.instr[RD_HI:RD_LO];
  assign id_imm16  = if_id.instr[IMM_HI:IMM_LO];
  assign id_itype  = decode_type(id_op);
  assign id_is_hlt = if_id.valid && (id_itype == HALT);

  // R0 reads as zero; a same-cycle WB write to the source is bypassed in.
  always_comb begin
    id_a = '0;
    id_b = '0;
    if (id_rs != 5'd0) id_a = (wb_we && mem_wb.dest == id_rs) ? mem_wb.result : REG_BANK[id_rs];
    if (id_rt != 5'd0) id_b = (wb_we && mem_wb.dest == id_rt) ? mem_wb.result : REG_BANK[id_rt];
  end

  // ---------------- EX ----------------
  logic [XLEN-1:0] alu_b, alu_y, ex_target;
  logic            ex_taken;

  assign alu_b = (id_ex.itype == RR_ALU) ? id_ex.b : id_ex.imm;

  mips_64_alu #(.XLEN(XLEN)) u_alu (
    .op     (id_ex.alu_op),
    .a      (id_ex.a),
    .b      (alu_b),
    .result (alu_y)
  );

  // BEQZ takes on zero, BNEQZ on non-zero: equality of the two predicates covers both.
  assign ex_taken  = id_ex.valid && (id_ex.itype == BRANCH) &&
                     ((id_ex.opcode == OP_BEQZ) == (id_ex.a == '0));
  assign ex_target = id_ex.npc + id_ex.imm;

  // ---------------- MEM ----------------
  logic [DA_W-1:0] mem_addr;
  logic            mem_we;
  logic [XLEN-1:0] mem_rdata;

  assign mem_addr  = ex_mem.alu_out[DA_W-1:0];
  assign mem_we    = ex_mem.valid && (ex_mem.itype == STORE) && !HALTED;
  assign mem_rdata = DATA_MEMORY[mem_addr];

  // ---------------- IF ----------------
  logic [63:0] fetch_word;
  logic        unused_fetch_hi;

  assign fetch_word      = INSTRUCTION_MEMORY[PC[IA_W-1:0]];
  assign unused_fetch_hi = ^fetch_word[63:32];

  // ---------------- next-state ----------------
  always_comb begin
    pc_d    = PC;
    if_id_d = '0;
    if (ex_taken) begin
      pc_d = ex_target;
    end else if (!(halt_pend || id_is_hlt)) begin
      pc_d          = PC + XLEN'(1);
      if_id_d.valid = 1'b1;
      if_id_d.instr = fetch_word[31:0];
      if_id_d.npc   = PC + XLEN'(1);
    end
  end

  always_comb begin
    id_ex_d = '0;
    // A taken branch in EX squashes whatever ID holds, including an HLT.
    if (!ex_taken) begin
      id_ex_d.valid  = if_id.valid;
      id_ex_d.itype  = id_itype;
      id_ex_d.opcode = id_op;
      id_ex_d.alu_op = decode_alu(id_op);
      id_ex_d.a      = id_a;
      id_ex_d.b      = id_b;
      id_ex_d.imm    = {{(XLEN-16){id_imm16[15]}}, id_imm16};
      id_ex_d.npc    = if_id.npc;
      id_ex_d.dest   = (id_itype == RR_ALU) ? id_rd : id_rt;
    end
  end

  always_comb begin
    ex_mem_d         = '0;
    ex_mem_d.valid   = id_ex.valid;
    ex_mem_d.itype   = id_ex.itype;
    ex_mem_d.alu_out = alu_y;
    ex_mem_d.b       = id_ex.b;
    ex_mem_d.dest    = id_ex.dest;
  end

  always_comb begin
    mem_wb_d        = '0;
    mem_wb_d.valid  = ex_mem.valid;
    mem_wb_d.itype  = ex_mem.itype;
    mem_wb_d.result = (ex_mem.itype == LOAD) ? mem_rdata : ex_mem.alu_out;
    mem_wb_d.dest   = ex_mem.dest;
  end

  // ---------------- pipeline state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      halt_pend    <= 1'b0;
      if_id        <= '0;
      id_ex        <= '0;
      ex_mem       <= '0;
      mem_wb       <= '0;
    end else begin
      PC           <= pc_d;
      TAKEN_BRANCH <= ex_taken;
      halt_pend    <= halt_pend | (id_is_hlt & ~ex_taken);
      HALTED       <= HALTED | (mem_wb.valid && mem_wb.itype == HALT);
      if_id        <= if_id_d;
      id_ex        <= id_ex_d;
      ex_mem       <= ex_mem_d;
      mem_wb       <= mem_wb_d;
    end
  end

  // Storage writes; pipeline bubbles during reset guarantee no writes then.
  always_ff @(posedge clk) begin
    if (wb_we)  REG_BANK[mem_wb.dest] <= mem_wb.result;
    if (mem_we) DATA_MEMORY[mem_addr] <= ex_mem.b;
  end

  assign halted = HALTED;

endmodule

// File: tb/tb_mips_64_core.sv
// tb/tb_mips_64_core.sv - scoreboard testbench for mips_64_core
module tb_mips_64_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  mips_64_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110, HLT = 6'b111111;

  localparam int K_REG = 0, K_DMEM = 1, K_PC = 2, K_HFLAG = 3, K_HPORT = 4, K_TB = 5;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        check_now = 1'b0;
  logic [31:0] prog[$];

  function automatic logic [31:0] rr(logic [5:0] op, int rd, int rs, int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
  endfunction

  function automatic logic [31:0] ri(logic [5:0] op, int rt, int rs, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] hlt();
    return {HLT, 26'b0};
  endfunction

  function automatic logic [31:0] dmy();
    return rr(OR_, 15, 7, 7);
  endfunction

  function automatic logic [63:0] actual(int kind, int idx);
    case (kind)
      K_REG:   return dut.REG_BANK[5'(idx)];
      K_DMEM:  return dut.DATA_MEMORY[10'(idx)];
      K_PC:    return dut.PC;
      K_HFLAG: return {63'b0, dut.HALTED};
      K_HPORT: return {63'b0, halted};
      K_TB:    return {63'b0, dut.TAKEN_BRANCH};
      default: return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  // Monitor: drains the scoreboard whenever the core reports halted, or on request.
  always @(negedge clk) begin
    if ((check_now || (rst_n && halted)) && sb.size() > 0) begin
      while (sb.size() > 0) begin
        exp_t        e;
        logic [63:0] act;
        e      = sb.pop_front();
        act    = actual(e.kind, e.idx);
        checks = checks + 1;
        if (act !== e.val) begin
          errors = errors + 1;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_val(string name, int kind, int idx, logic [63:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic flush_timeout(string tag, int budget);
    if (sb.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL timeout %s: %0d checks pending after %0d cycles, required 0", tag, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic sample_now(string tag);
    check_now = 1'b1;
    @(negedge clk);
    #1;
    check_now = 1'b0;
    flush_timeout(tag, 1);
  endtask

  task automatic begin_test();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 32; k++) dut.REG_BANK[k] <= 64'(k);
    for (int i = 0; i < 64; i++) dut.INSTRUCTION_MEMORY[i] <= {32'hDEAD_BEEF, hlt()};
    prog.delete();
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) dut.INSTRUCTION_MEMORY[i] <= {32'hDEAD_BEEF, prog[i]};
  endtask

  task automatic reset_checks(string tag);
    expect_val({tag, "_rst_pc"}, K_PC, 0, 64'd0);
    expect_val({tag, "_rst_halted_flag"}, K_HFLAG, 0, 64'd0);
    expect_val({tag, "_rst_halted_port"}, K_HPORT, 0, 64'd0);
    expect_val({tag, "_rst_taken"}, K_TB, 0, 64'd0);
    sample_now({tag, "_rst"});
  endtask

  task automatic run_to_halt(string tag);
    int n;
    n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    while (sb.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    flush_timeout(tag, 3000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    // ---------------- add chain ----------------
    begin_test();
    prog.push_back(ri(ADDI, 1, 0, 16'd10));
    prog.push_back(ri(ADDI, 2, 0, 16'd20));
    prog.push_back(ri(ADDI, 3, 0, 16'd25));
    prog.push_back(dmy());
    prog.push_back(dmy());
    prog.push_back(rr(ADD, 4, 1, 2));
    prog.push_back(dmy());
    prog.push_back(dmy());
    prog.push_back(rr(ADD, 5, 4, 3));
    prog.push_back(hlt());
    load_prog();
    reset_checks("add");
    expect_val("add_r1", K_REG, 1, 64'd10);
    expect_val("add_r2", K_REG, 2, 64'd20);
    expect_val("add_r3", K_REG, 3, 64'd25);
    expect_val("add_r4", K_REG, 4, 64'd30);
    expect_val("add_r5", K_REG, 5, 64'd55);
    expect_val("add_r0", K_REG, 0, 64'd0);
    expect_val("add_halted", K_HPORT, 0, 64'd1);
    run_to_halt("add");

    // ---------------- load/store ----------------
    begin_test();
    dut.DATA_MEMORY[120] <= 64'd85;
    dut.DATA_MEMORY[121] <= 64'd0;
    prog.push_back(ri(ADDI, 1, 0, 16'd120));
    prog.push_back(dmy());
    prog.push_back(dmy());
    prog.push_back(ri(LW, 2, 1, 16'd0));
    prog.push_back(dmy());
    prog.push_back(dmy());
    prog.push_back(dmy());
    prog.push_back(ri(ADDI, 2, 2, 16'd45));
    prog.push_back(dmy());
    prog.push_back(dmy());
    prog.push_back(ri(SW, 2, 1, 16'd1));
    prog.push_back(hlt());
    load_prog();
    reset_checks("ldst");
    expect_val("ldst_mem121", K_DMEM, 121, 64'd130);
    expect_val("ldst_mem120", K_DMEM, 120, 64'd85);
    expect_val("ldst_r2", K_REG, 2, 64'd130);
    run_to_halt("ldst");

    // ---------------- factorial loop; HLT sits in the branch shadow ----------------
    begin_test();
    prog.push_back(ri(ADDI, 10, 0, 16'd7));
    prog.push_back(ri(ADDI, 3, 0, 16'd1));
    prog.push_back(dmy());
    prog.push_back(dmy());
    prog.push_back(rr(MUL, 3, 3, 10));
    prog.push_back(ri(SUBI, 10, 10, 16'd1));
    prog.push_back(dmy());
    prog.push_back(dmy());
    prog.push_back(ri(BNEQZ, 0, 10, 16'hFFFB));
    prog.push_back(hlt());
    prog.push_back(ri(ADDI, 20, 0, 16'd77));
    load_prog();
    reset_checks("fact");
    expect_val("fact_r3", K_REG, 3, 64'd5040);
    expect_val("fact_r10", K_REG, 10, 64'd0);
    expect_val("fact_shadow_r20", K_REG, 20, 64'd20);
    expect_val("fact_taken_at_halt", K_TB, 0, 64'd0);
    run_to_halt("fact");

    // ---------------- ALU corners ----------------
    begin_test();
    prog.push_back(ri(SUBI, 4, 0, 16'd1));
    prog.push_back(ri(SLTI, 2, 0, 16'hFFFF));
    prog.push_back(ri(ADDI, 3, 0, 16'h8000));
    prog.push_back(ri(ADDI, 0, 0, 16'd5));
    prog.push_back(rr(SLT, 7, 4, 1));
    prog.push_back(rr(SUB, 1, 0, 31));
    prog.push_back(rr(AND_, 9, 31, 13));
    prog.push_back(rr(OR_, 12, 16, 8));
    prog.push_back(rr(MUL, 13, 3, 3));
    prog.push_back(hlt());
    load_prog();
    reset_checks("alu");
    expect_val("alu_subi_neg1", K_REG, 4, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_val("alu_slti_0_lt_m1", K_REG, 2, 64'd0);
    expect_val("alu_addi_sext", K_REG, 3, 64'hFFFF_FFFF_FFFF_8000);
    expect_val("alu_r0_kept", K_REG, 0, 64'd0);
    expect_val("alu_slt_m1_lt_1", K_REG, 7, 64'd1);
    expect_val("alu_sub_wrap", K_REG, 1, 64'hFFFF_FFFF_FFFF_FFE1);
    expect_val("alu_and", K_REG, 9, 64'd13);
    expect_val("alu_or", K_REG, 12, 64'd24);
    expect_val("alu_mul", K_REG, 13, 64'h0000_0000_4000_0000);
    run_to_halt("alu");

    // ---------------- reset mid-run ----------------
    begin_test();
    prog.push_back(ri(ADDI, 5, 5, 16'd100));
    prog.push_back(dmy());
    prog.push_back(dmy());
    prog.push_back(dmy());
    prog.push_back(rr(ADD, 6, 6, 1));
    prog.push_back(hlt());
    load_prog();
    reset_checks("mrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    expect_val("mrst_pc", K_PC, 0, 64'd0);
    expect_val("mrst_halted_flag", K_HFLAG, 0, 64'd0);
    expect_val("mrst_r5_written", K_REG, 5, 64'd105);
    expect_val("mrst_r6_aborted", K_REG, 6, 64'd6);
    sample_now("mrst_abort");
    repeat (3) @(posedge clk);
    #1;
    expect_val("mrst_r6_still", K_REG, 6, 64'd6);
    sample_now("mrst_hold");
    expect_val("mrst_rerun_r5", K_REG, 5, 64'd205);
    expect_val("mrst_rerun_r6", K_REG, 6, 64'd7);
    run_to_halt("mrst");

    // ---------------- halt behaviour ----------------
    begin_test();
    prog.push_back(hlt());
    prog.push_back(ri(ADDI, 6, 0, 16'd99));
    prog.push_back(ri(ADDI, 7, 0, 16'd98));
    load_prog();
    reset_checks("hlt");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    expect_val("hlt_not_yet", K_HPORT, 0, 64'd0);
    expect_val("hlt_pc_frozen_early", K_PC, 0, 64'd1);
    sample_now("hlt_e3");
    @(posedge clk);
    #1;
    expect_val("hlt_rise_port", K_HPORT, 0, 64'd1);
    expect_val("hlt_rise_flag", K_HFLAG, 0, 64'd1);
    sample_now("hlt_e4");
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      expect_val("hlt_stays", K_HPORT, 0, 64'd1);
      expect_val("hlt_pc_frozen", K_PC, 0, 64'd1);
      sample_now("hlt_hold");
    end
    expect_val("hlt_r6_unchanged", K_REG, 6, 64'd6);
    expect_val("hlt_r7_unchanged", K_REG, 7, 64'd7);
    sample_now("hlt_regs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
